// File: rtl/des_keysched_seq.sv
// des_keysched_seq: streams 16 DES round keys per key of a bundle over valid/ready; encrypt or decrypt order per key.
// Optional macro DES_KEYSCHED_PARITY_CHK_EN adds odd-parity checking of every key byte at accept.
module des_keysched_seq #(
  parameter int NUM_KEYS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [64*NUM_KEYS-1:0]  key_in,
  input  logic [NUM_KEYS-1:0]     mode_in,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [47:0]             rk_data,
  output logic [3:0]              rk_round,
  output logic [1:0]              rk_key_idx,
  output logic                    rk_last,
  output logic                    parity_err
);
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                              10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                              14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                              23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  typedef enum logic {IDLE, GEN} state_t;
  state_t state, state_nx;
  logic [NUM_KEYS-1:0][55:0] cd_in;
  logic [3:0][55:0] cd_pad, cd_q;
  logic [3:0] mode_pad, mode_q;
  logic [27:0] c, d;
  logic [55:0] cd, ld_cd;
  logic [47:0] rk;
  logic [3:0] rnd;
  logic [1:0] kidx, nk;
  logic accept, hs, last, ld_mode, two;
  function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic by2);
    return right ? (by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]})
                 : (by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
  endfunction
  // PC-1 of every offered key; parity bits never reach the schedule
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    for (genvar i = 0; i < 56; i++) begin : g_pc1
      assign cd_in[k][55-i] = key_in[64*k+64-PC1[i]];
    end
  end
  assign cd = {c, d};
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign rk[47-i] = cd[56-PC2[i]];
  end
  always_comb begin
    cd_pad = '0;
    cd_pad[NUM_KEYS-1:0] = cd_in;
    mode_pad = '0;
    mode_pad[NUM_KEYS-1:0] = mode_in;
  end
  assign accept = key_valid & key_ready;
  assign hs = rk_valid & rk_ready;
  assign last = rnd == 4'd15 && kidx == 2'(NUM_KEYS - 1);
  assign nk = kidx + 2'd1;
  assign ld_cd = accept ? cd_in[0] : cd_q[nk];
  assign ld_mode = accept ? mode_in[0] : mode_q[nk];
  // single-step rotation before rounds 2, 9, 16 (and the matching decrypt beats)
  assign two = !(rnd == 4'd0 || rnd == 4'd7 || rnd == 4'd14);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? GEN : IDLE) : (hs && last ? IDLE : GEN);
  always_comb begin
    key_ready = state == IDLE;
    rk_valid = state == GEN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cd_q <= '0;
      mode_q <= '0;
      c <= '0;
      d <= '0;
      rnd <= '0;
      kidx <= '0;
    end else if (accept || (hs && rnd == 4'd15 && !last)) begin
      c <= ld_mode ? ld_cd[55:28] : rot(ld_cd[55:28], 1'b0, 1'b0);
      d <= ld_mode ? ld_cd[27:0] : rot(ld_cd[27:0], 1'b0, 1'b0);
      rnd <= '0;
      kidx <= accept ? 2'd0 : nk;
      if (accept) begin
        cd_q <= cd_pad;
        mode_q <= mode_pad;
      end
    end else if (hs && !last) begin
      c <= rot(c, mode_q[kidx], two);
      d <= rot(d, mode_q[kidx], two);
      rnd <= rnd + 4'd1;
    end
  assign rk_data = rk_valid ? rk : '0;
  assign rk_round = rk_valid ? rnd : '0;
  assign rk_key_idx = rk_valid ? kidx : '0;
  assign rk_last = rk_valid & last;
`ifdef DES_KEYSCHED_PARITY_CHK_EN
  logic [8*NUM_KEYS-1:0] byte_bad;
  for (genvar j = 0; j < 8*NUM_KEYS; j++) begin : g_par
    assign byte_bad[j] = ~^key_in[8*j +: 8];
  end
  always_ff @(posedge clk)
    if (rst) parity_err <= 1'b0;
    else if (accept) parity_err <= |byte_bad;
`else
  logic unused_key;
  assign unused_key = ^key_in;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_keysched_seq.sv
// tb_des_keysched_seq: randomized bench for des_keysched_seq against a cumulative-shift DES key schedule model.
module tb_des_keysched_seq;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
`ifdef DES_KEYSCHED_PARITY_CHK_EN
  localparam bit PERR = 1'b1;
`else
  localparam bit PERR = 1'b0;
`endif
  logic kv1 = 0, rr1 = 0, kr1, rv1, rl1, pe1;
  logic [63:0] ki1 = '0;
  logic [0:0] mi1 = '0;
  logic [47:0] rd1;
  logic [3:0] rn1;
  logic [1:0] rx1;
  logic kv3 = 0, rr3 = 0, kr3, rv3, rl3, pe3;
  logic [191:0] ki3 = '0;
  logic [2:0] mi3 = '0;
  logic [47:0] rd3;
  logic [3:0] rn3;
  logic [1:0] rx3;
  int checks = 0, errors = 0;
  des_keysched_seq #(.NUM_KEYS(1)) u1 (.clk(clk), .rst(rst), .key_valid(kv1), .key_ready(kr1),
    .key_in(ki1), .mode_in(mi1), .rk_valid(rv1), .rk_ready(rr1), .rk_data(rd1), .rk_round(rn1),
    .rk_key_idx(rx1), .rk_last(rl1), .parity_err(pe1));
  des_keysched_seq #(.NUM_KEYS(3)) u3 (.clk(clk), .rst(rst), .key_valid(kv3), .key_ready(kr3),
    .key_in(ki3), .mode_in(mi3), .rk_valid(rv3), .rk_ready(rr3), .rk_data(rd3), .rk_round(rn3),
    .rk_key_idx(rx3), .rk_last(rl3), .parity_err(pe3));
  int pc1_t [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int pc2_t [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                     23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Kn from C0,D0 rotated left by the total shift count up to round n
  function automatic logic [47:0] subkey(input logic [63:0] k, input int n);
    logic [55:0] v;
    logic [27:0] c, d;
    logic [47:0] o;
    int s = 0;
    for (int i = 0; i < 56; i++) v[55-i] = k[64-pc1_t[i]];
    for (int r = 0; r < n; r++) s += sh_t[r];
    c = v[55:28];
    d = v[27:0];
    for (int i = 0; i < s; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    v = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = v[56-pc2_t[i]];
    return o;
  endfunction
  function automatic logic [47:0] exp_rk(input logic [63:0] k, input logic m, input int r);
    return subkey(k, m ? 16 - r : r + 1);
  endfunction
  task automatic run1(input logic [63:0] k, input logic m, input string nm,
                      output logic [47:0] first, output logic [47:0] final_rk);
    @(negedge clk);
    checks++;
    if (kr1 !== 1'b1) begin errors++; $display("FAIL %s_ready got %0b want 1", nm, kr1); end
    kv1 = 1; ki1 = k; mi1 = m; rr1 = 1;
    @(negedge clk);
    kv1 = 0; ki1 = {$urandom, $urandom}; mi1 = ~m;
    first = rd1;
    final_rk = '0;
    for (int b = 0; b < 16; b++) begin
      checks++;
      if (rv1 !== 1'b1 || rd1 !== exp_rk(k, m, b) || rn1 !== 4'(b) || rx1 !== 2'd0 || rl1 !== (b == 15)) begin
        errors++;
        $display("FAIL %s_beat%0d got v=%0b d=%h r=%0d x=%0d l=%0b want v=1 d=%h r=%0d x=0 l=%0b",
                 nm, b, rv1, rd1, rn1, rx1, rl1, exp_rk(k, m, b), b, b == 15);
      end
      final_rk = rd1;
      @(negedge clk);
    end
    checks++;
    if (kr1 !== 1'b1 || rv1 !== 1'b0) begin
      errors++; $display("FAIL %s_end got ready=%0b valid=%0b want 1 0", nm, kr1, rv1);
    end
    rr1 = 0;
  endtask
  task automatic run3(input logic [191:0] keys, input logic [2:0] modes, input int pct,
                      input int rst_at, input string nm);
    int beat = 0, cyc = 0, j, r;
    bit stall = 0;
    logic [47:0] e, pd;
    logic [3:0] pr;
    logic [1:0] px;
    @(negedge clk);
    checks++;
    if (kr3 !== 1'b1) begin errors++; $display("FAIL %s_ready got %0b want 1", nm, kr3); end
    kv3 = 1; ki3 = keys; mi3 = modes; rr3 = 0;
    @(negedge clk);
    kv3 = 0; ki3 = {6{$urandom}}; mi3 = 3'($urandom);
    checks++;
    if (rv3 !== 1'b1) begin errors++; $display("FAIL %s_first_valid got %0b want 1", nm, rv3); end
    while (beat < 48 && cyc < 600) begin
      j = beat / 16; r = beat % 16;
      e = exp_rk(keys[64*j +: 64], modes[j], r);
      checks++;
      if (rv3 !== 1'b1 || rd3 !== e || rn3 !== 4'(r) || rx3 !== 2'(j) || rl3 !== (beat == 47)) begin
        errors++;
        $display("FAIL %s_beat%0d got v=%0b d=%h r=%0d x=%0d l=%0b want v=1 d=%h r=%0d x=%0d l=%0b",
                 nm, beat, rv3, rd3, rn3, rx3, rl3, e, r, j, beat == 47);
      end
      if (stall) begin
        checks++;
        if (rd3 !== pd || rn3 !== pr || rx3 !== px) begin
          errors++; $display("FAIL %s_hold%0d got d=%h r=%0d x=%0d want d=%h r=%0d x=%0d",
                             nm, beat, rd3, rn3, rx3, pd, pr, px);
        end
      end
      if (beat == rst_at && !rst) rst = 1;
      rr3 = $urandom_range(99) < pct;
      kv3 = pct < 100 ? 1'($urandom_range(1)) : 1'b0;
      ki3 = {6{$urandom}}; mi3 = 3'($urandom);
      stall = !rr3; pd = rd3; pr = rn3; px = rx3;
      if (rr3) beat++;
      cyc++;
      @(negedge clk);
      if (rst) break;
    end
    kv3 = 0;
    if (rst) begin
      checks++;
      if (rv3 !== 1'b0 || kr3 !== 1'b1 || rd3 !== '0 || rn3 !== '0 || rx3 !== '0 || rl3 !== 1'b0) begin
        errors++; $display("FAIL %s_after_rst got v=%0b rdy=%0b d=%h r=%0d x=%0d l=%0b want 0 1 0 0 0 0",
                           nm, rv3, kr3, rd3, rn3, rx3, rl3);
      end
      rst = 0;
    end else begin
      checks++;
      if (beat != 48 || (pct == 100 && cyc != 48)) begin
        errors++; $display("FAIL %s_beats got %0d in %0d cycles want 48", nm, beat, cyc);
      end
      checks++;
      if (kr3 !== 1'b1 || rv3 !== 1'b0) begin
        errors++; $display("FAIL %s_end got ready=%0b valid=%0b want 1 0", nm, kr3, rv3);
      end
    end
    rr3 = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (kr1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== '0 || rn1 !== '0 || rx1 !== '0 || rl1 !== 1'b0 || pe1 !== 1'b0 ||
        kr3 !== 1'b1 || rv3 !== 1'b0 || rd3 !== '0 || rn3 !== '0 || rx3 !== '0 || rl3 !== 1'b0 || pe3 !== 1'b0) begin
      errors++; $display("FAIL reset got rdy=%0b/%0b v=%0b/%0b d=%h/%h want rdy=1 v=0 d=0", kr1, kr3, rv1, rv3, rd1, rd3);
    end
    rst = 0;
  endtask
  task automatic test_encrypt;
    logic [47:0] f, l;
    run1(64'h133457799BBCDFF1, 1'b0, "enc", f, l);
    checks++;
    if (f !== 48'h1B02EFFC7072 || l !== 48'hCB3D8B0E17F5) begin
      errors++; $display("FAIL enc_kat got %h %h want 1b02effc7072 cb3d8b0e17f5", f, l);
    end
  endtask
  task automatic test_decrypt;
    logic [47:0] f, l;
    run1(64'h133457799BBCDFF1, 1'b1, "dec", f, l);
    checks++;
    if (f !== 48'hCB3D8B0E17F5 || l !== 48'h1B02EFFC7072) begin
      errors++; $display("FAIL dec_kat got %h %h want cb3d8b0e17f5 1b02effc7072", f, l);
    end
  endtask
  task automatic test_parity;
    @(negedge clk);
    kv1 = 1; ki1 = 64'h133457799BBCDFF0; mi1 = 0; rr1 = 0;
    @(negedge clk);
    kv1 = 0;
    checks++;
    if (pe1 !== PERR) begin errors++; $display("FAIL parity_set got %0b want %0b", pe1, PERR); end
    rr1 = 1;
    repeat (16) @(negedge clk);
    checks++;
    if (pe1 !== PERR || kr1 !== 1'b1) begin
      errors++; $display("FAIL parity_hold got err=%0b rdy=%0b want %0b 1", pe1, kr1, PERR);
    end
    kv1 = 1; ki1 = 64'h133457799BBCDFF1;
    @(negedge clk);
    kv1 = 0;
    checks++;
    if (pe1 !== 1'b0) begin errors++; $display("FAIL parity_clear got %0b want 0", pe1); end
    repeat (16) @(negedge clk);
    rr1 = 0;
  endtask
  logic [191:0] tdes_keys;
  task automatic test_tdes;
    tdes_keys = {{$urandom, $urandom}, {$urandom, $urandom}, 64'h133457799BBCDFF1};
    run3(tdes_keys, 3'b010, 100, -1, "tdes");
  endtask
  task automatic test_stall;
    run3(tdes_keys, 3'b010, 50, -1, "stall");
  endtask
  task automatic test_mid_reset;
    run3({6{$urandom}}, 3'b101, 100, 23, "midrst");
    run3({6{$urandom}}, 3'($urandom), 100, -1, "post_rst");
  endtask
  task automatic test_random;
    for (int n = 0; n < 3; n++) run3({6{$urandom}}, 3'($urandom), 70, -1, "rand");
  endtask
  initial begin
    test_reset;
    test_encrypt;
    test_decrypt;
    test_parity;
    test_tdes;
    test_stall;
    test_mid_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
